// File: rtl/ddi_phase_scheduler_pkg.sv
// Light-state and phase encodings, default dwell lengths and phase helpers shared by the scheduler.
// Pure declarations: no timing and no flow control of its own.
package ddi_phase_scheduler_pkg;

  typedef enum logic [3:0] {
    ALL_RED          = 4'd0,
    PHASE_1_GREEN    = 4'd1,
    PHASE_1_YELLOW   = 4'd2,
    PHASE_2_GREEN    = 4'd3,
    PHASE_2_YELLOW   = 4'd4,
    EASTBOUND_GREEN  = 4'd5,
    EASTBOUND_YELLOW = 4'd6,
    WESTBOUND_GREEN  = 4'd7,
    WESTBOUND_YELLOW = 4'd8,
    MAINTENANCE      = 4'd9
  } light_state_t;

  typedef enum logic [1:0] {
    PHASE_1       = 2'd0,
    PHASE_2       = 2'd1,
    EAST_PRIORITY = 2'd2,
    WEST_PRIORITY = 2'd3
  } phase_t;

  localparam int DEF_GREEN_TICKS      = 20;
  localparam int DEF_PRIO_GREEN_TICKS = 10;
  localparam int DEF_YELLOW_TICKS     = 4;
  localparam int DEF_RED_TICKS        = 2;
  localparam int DEF_CNT_W            = 8;

  function automatic logic is_priority(phase_t p);
    return (p == EAST_PRIORITY) || (p == WEST_PRIORITY);
  endfunction

  function automatic phase_t next_normal(phase_t p);
    return (p == PHASE_1) ? PHASE_2 : PHASE_1;
  endfunction

endpackage

// File: rtl/ddi_phase_scheduler_if.sv
// Scheduler <-> light controller link: state and requests in, dwell pulse and next phase out.
// Purely wiring; no handshake, the controller advances on timing_done.
interface ddi_phase_scheduler_if;
  import ddi_phase_scheduler_pkg::*;

  light_state_t current_state;
  logic         east_req;
  logic         west_req;
  logic         timing_done;
  phase_t       phase;

  modport master (
    output current_state, east_req, west_req,
    input  timing_done, phase
  );

  modport slave (
    input  current_state, east_req, west_req,
    output timing_done, phase
  );

endinterface

// File: rtl/ddi_phase_scheduler_dwell_counter.sv
// Dwell counter: load on a new dwell, count down, and fire a registered one-shot in cycle D.
// done rises one edge after the remaining count reaches 2; holds still while inactive.
module ddi_phase_scheduler_dwell_counter #(
  parameter int CNT_W     = 8,
  parameter int RST_TICKS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             active,
  input  logic [CNT_W-1:0] ticks,
  output logic             done
);

  // cnt is the number of cycles left in the dwell, counting the current one
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_eff;

  always_comb begin
    cnt_eff = load ? ticks : cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= CNT_W'(RST_TICKS);
      done <= 1'b0;
    end else if (!active) begin
      done <= 1'b0;
    end else begin
      done <= (cnt_eff == CNT_W'(2));
      cnt  <= (cnt_eff == '0) ? '0 : cnt_eff - 1'b1;
    end
  end

endmodule

// File: rtl/ddi_phase_scheduler.sv
// Phase scheduler: times each light state and picks the phase served after every ALL_RED.
// Outputs registered; timing_done one cycle wide, phase updated at the first edge of ALL_RED.
module ddi_phase_scheduler
  import ddi_phase_scheduler_pkg::*;
#(
  parameter int GREEN_TICKS      = DEF_GREEN_TICKS,
  parameter int PRIO_GREEN_TICKS = DEF_PRIO_GREEN_TICKS,
  parameter int YELLOW_TICKS     = DEF_YELLOW_TICKS,
  parameter int RED_TICKS        = DEF_RED_TICKS,
  parameter int CNT_W            = DEF_CNT_W
) (
  input logic                  clk,
  input logic                  rst,
  ddi_phase_scheduler_if.slave bus
);

  light_state_t     state_q;
  logic             state_chg;
  logic [CNT_W-1:0] ticks;
  logic             active;
  logic             done;
  logic             east_pend;
  logic             west_pend;
  phase_t           phase_q;
  phase_t           rot;
  phase_t           last;

  // Reset copy is ALL_RED so the first post-reset cycle continues an ALL_RED dwell without a selection
  always_ff @(posedge clk) begin
    if (rst) state_q <= ALL_RED;
    else     state_q <= bus.current_state;
  end

  assign state_chg = (bus.current_state != state_q);

  always_comb begin
    ticks  = '0;
    active = 1'b1;
    case (bus.current_state)
      ALL_RED:                            ticks = CNT_W'(RED_TICKS);
      PHASE_1_GREEN, PHASE_2_GREEN:       ticks = CNT_W'(GREEN_TICKS);
      EASTBOUND_GREEN, WESTBOUND_GREEN:   ticks = CNT_W'(PRIO_GREEN_TICKS);
      PHASE_1_YELLOW, PHASE_2_YELLOW,
      EASTBOUND_YELLOW, WESTBOUND_YELLOW: ticks = CNT_W'(YELLOW_TICKS);
      default:                            active = 1'b0;
    endcase
  end

  ddi_phase_scheduler_dwell_counter #(
    .CNT_W     (CNT_W),
    .RST_TICKS (RED_TICKS)
  ) u_dwell_counter (
    .clk    (clk),
    .rst    (rst),
    .load   (state_chg),
    .active (active),
    .ticks  (ticks),
    .done   (done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      east_pend <= 1'b0;
      west_pend <= 1'b0;
    end else begin
      if (bus.current_state == EASTBOUND_GREEN)
        east_pend <= 1'b0;
      else if (bus.east_req && bus.current_state != EASTBOUND_YELLOW)
        east_pend <= 1'b1;
      if (bus.current_state == WESTBOUND_GREEN)
        west_pend <= 1'b0;
      else if (bus.west_req && bus.current_state != WESTBOUND_YELLOW)
        west_pend <= 1'b1;
    end
  end

  // A priority phase is always followed by a normal one, so neither side starves the rotation
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PHASE_1;
      rot     <= PHASE_2;
      last    <= PHASE_1;
    end else if (state_chg && bus.current_state == ALL_RED) begin
      if (!is_priority(last) && east_pend) begin
        phase_q <= EAST_PRIORITY;
        last    <= EAST_PRIORITY;
      end else if (!is_priority(last) && west_pend) begin
        phase_q <= WEST_PRIORITY;
        last    <= WEST_PRIORITY;
      end else begin
        phase_q <= rot;
        last    <= rot;
        rot     <= next_normal(rot);
      end
    end
  end

  assign bus.timing_done = done;
  assign bus.phase       = phase_q;

endmodule
